response_router: RTL
====================

RESPONSE_ROUTER -- requirements
Module: response_router

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4: number of requesting units; the one-hot width.
REQ-002 SHALL have parameter DEPTH, default 4: maximum outstanding requests; a power of two, at least 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: response payload width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port grant_oh, input, NUM_ENTRIES: one-hot arbiter grant for the request issued this cycle.
REQ-007 SHALL have port issue_valid, input, 1: the granted request is issued to the shared resource this cycle.
REQ-008 SHALL have port issue_ready, output, 1: the tracker can record another outstanding request.
REQ-009 SHALL have port resp_valid, input, 1: the shared resource returns a response this cycle.
REQ-010 SHALL have port resp_data, input, DATA_WIDTH: response payload.
REQ-011 SHALL have port resp_valid_oh, output, NUM_ENTRIES: registered one-hot response strobe to the originating unit.
REQ-012 SHALL have port resp_data_out, output, DATA_WIDTH: registered response payload.
REQ-013 SHALL have port outstanding, output, $clog2(DEPTH)+1: count of recorded, unanswered requests.

Function
REQ-014 SHALL push grant_oh into an in-order tracker FIFO when issue_valid && issue_ready (an accepted issue).
REQ-015 SHALL drive issue_ready = (outstanding != DEPTH), from registered state only, with no combinational path from resp_valid or issue_valid.
REQ-016 SHALL ignore issue_valid while issue_ready is low: no push, no state change.
REQ-017 SHALL treat the shared resource as in-order: each resp_valid with outstanding != 0 pops the oldest entry.
REQ-018 SHALL, for resp_valid in cycle N with a pop, drive resp_valid_oh = the popped entry and resp_data_out = resp_data in cycle N+1; latency is exactly 1.
REQ-019 SHALL hold resp_valid_oh at 0 in every cycle following a cycle with no pop; resp_data_out holds its last value.
REQ-020 SHALL drop a resp_valid arriving when outstanding == 0: no pop, no strobe.
REQ-021 SHALL, on a simultaneous push and pop, leave outstanding unchanged and keep FIFO order (pop oldest, append newest).
REQ-022 SHALL, on a simultaneous push and resp_valid with outstanding == 0, drop the response and record the push; the new entry waits for a later response.
REQ-023 SHALL, when full with a simultaneous pop, still hold issue_ready low that cycle; the freed slot is usable from the next cycle.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; outstanding ranges 0..DEPTH and never over- or underflows.
REQ-025 SHALL store a non-one-hot grant_oh unchanged and return it unchanged.

Reset
REQ-026 SHALL, while reset is high at a clock edge, clear pointers, outstanding, resp_valid_oh and resp_data_out to 0 and set issue_ready to 1.
REQ-027 SHALL, on reset mid-operation, discard all outstanding entries; responses after reset are dropped per REQ-020.

Configuration
REQ-028 SHALL add an output error (1 bit) when macro RESPONSE_ROUTER_CHECK_EN is defined.
REQ-029 SHALL, with RESPONSE_ROUTER_CHECK_EN defined, set error sticky on any of: a dropped response (REQ-020/022), an accepted issue with grant_oh not one-hot, or issue_valid while issue_ready is low.
REQ-030 SHALL clear error only on reset.
REQ-031 SHALL, without RESPONSE_ROUTER_CHECK_EN, have no error port and no check logic; all other behaviour is identical.

Structure
REQ-032 SHALL take default parameter values and the macro name from the team's shared core defines file; no new package.
REQ-033 SHALL implement the tracker as one sub-module, sync_fifo (WIDTH=NUM_ENTRIES, DEPTH), exposing count, full and empty; routing and output registers live in response_router.

Verification
REQ-034 SHALL cover in-order routing: issue 4'b0001, 4'b0100, 4'b1000, then 3 responses 0xA, 0xB, 0xC -> resp_valid_oh 0001/0xA, 0100/0xB, 1000/0xC, each one cycle after its response.
REQ-035 SHALL cover full: DEPTH=4, 4 issues, no responses -> issue_ready=0 and outstanding=4; a 5th issue is ignored; after 1 response, issue_ready=1 on the next cycle.
REQ-036 SHALL cover simultaneous events: outstanding=2, push 4'b0010 together with a response -> outstanding stays 2, oldest entry routed, 4'b0010 returned last.
REQ-037 SHALL cover empty: resp_valid with outstanding=0 -> resp_valid_oh stays 0; with the macro defined, error=1 until reset.
REQ-038 SHALL cover reset mid-operation: outstanding=3, assert reset for 1 cycle -> outstanding=0, issue_ready=1; the next response is dropped.
REQ-039 SHALL cover wrap-around: 10 push/pop pairs with alternating grants -> every response routed to its matching grant.

Source files
------------

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock in-order FIFO with occupancy count and full/empty
//            flags. Read data is the head entry, available combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // Flags derive only from the registered count, so no input reaches them.
    assign full      = (r_count == c_cnt_max);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Storage array: written at the tail, no reset needed for payload.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/response_router.sv
`default_nettype none
// ============================================================================
// Module   : response_router
// Brief    : Records the one-hot grant of every issued request in an in-order
//            tracker and routes each in-order response back to its requester
//            with a registered one-cycle-latency strobe and payload.
//            Optional checker enabled by macro RESPONSE_ROUTER_CHECK_EN adds a
//            sticky 'error' output.
// Revision : 1.0 - initial release
// ============================================================================
module response_router #(
    parameter int NUM_ENTRIES = 4,
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_ENTRIES-1:0]      grant_oh,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic                        resp_valid,
    input  logic [DATA_WIDTH-1:0]       resp_data,
    output logic [NUM_ENTRIES-1:0]      resp_valid_oh,
    output logic [DATA_WIDTH-1:0]       resp_data_out,
    output logic [$clog2(DEPTH):0]      outstanding
`ifdef RESPONSE_ROUTER_CHECK_EN
    ,
    output logic                        error
`endif
);
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_pop;
    logic [NUM_ENTRIES-1:0] w_head;

    logic [NUM_ENTRIES-1:0] r_resp_valid_oh;
    logic [DATA_WIDTH-1:0]  r_resp_data_out;

    // Ready depends only on tracker occupancy, never on same-cycle inputs.
    assign issue_ready   = !w_full;
    assign w_accept      = issue_valid && issue_ready;
    // A response with nothing outstanding is dropped.
    assign w_pop         = resp_valid && !w_empty;
    assign resp_valid_oh = r_resp_valid_oh;
    assign resp_data_out = r_resp_data_out;

    sync_fifo #(
        .WIDTH (NUM_ENTRIES),
        .DEPTH (DEPTH)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .push      (w_accept),
        .push_data (grant_oh),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (outstanding),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Output registers: strobe the popped grant for one cycle, hold payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid_oh <= '0;
            r_resp_data_out <= '0;
        end else begin
            r_resp_valid_oh <= w_pop ? w_head : '0;
            if (w_pop) begin
                r_resp_data_out <= resp_data;
            end
        end
    end

`ifdef RESPONSE_ROUTER_CHECK_EN
    logic w_grant_onehot;
    logic w_violation;
    logic r_error;

    assign w_grant_onehot = (grant_oh != '0) &&
                            ((grant_oh & (grant_oh - NUM_ENTRIES'(1))) == '0);
    assign w_violation    = (resp_valid && w_empty) ||
                            (w_accept && !w_grant_onehot) ||
                            (issue_valid && !issue_ready);
    assign error          = r_error;

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_violation) begin
            r_error <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
